// File: rtl/gear_switch_conditioner.sv
// gear_switch_conditioner: synchronizes, debounces and validates the four raw
// gear selector switches {P,R,N,D} into a one-hot gear request.
// Optional feature macro: GEAR_SW_STICKY_ERR_EN (sticky conflict flag with err_clr).
module gear_switch_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [3:0] RESET_GEAR      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_raw,
    input  logic       err_clr,
    output logic [3:0] gear_out,
    output logic       gear_chg,
    output logic       conflict
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NONE     = 2'd0,
        ST_VALID    = 2'd1,
        ST_CONFLICT = 2'd2
    } state_t;

    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         r_stable;
    logic [3:0][CW-1:0] r_cnt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         w_pop;
    logic [3:0]         r_gear;
    logic               r_chg;

    // Two-flop synchronizer per switch bit, nothing between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // mismatching cycles; any agreement restarts the count, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_pop = 3'(r_stable[0]) + 3'(r_stable[1]) + 3'(r_stable[2]) + 3'(r_stable[3]);

    // Validation state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_NONE;
        else        r_state <= w_state_nxt;
    end

    // Next state depends only on the stable popcount, so any state is reachable
    // from any other in the same cycle the popcount changes.
    always_comb begin
        w_state_nxt = ST_NONE;
        if (w_pop == 3'd1)      w_state_nxt = ST_VALID;
        else if (w_pop >= 3'd2) w_state_nxt = ST_CONFLICT;
    end

    // Output gear register; the change pulse aligns with the new gear value and a
    // re-selection of the held gear is not a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gear <= RESET_GEAR;
            r_chg  <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            if (w_state_nxt == ST_VALID && r_stable != r_gear) begin
                r_gear <= r_stable;
                r_chg  <= 1'b1;
            end
        end
    end

    assign gear_out = r_gear;
    assign gear_chg = r_chg;

`ifdef GEAR_SW_STICKY_ERR_EN
    logic r_conflict;

    // Sticky conflict: set on CONFLICT (set wins over clear), cleared by err_clr
    // only once the selector has left CONFLICT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_conflict <= 1'b0;
        else if (w_state_nxt == ST_CONFLICT)         r_conflict <= 1'b1;
        else if (err_clr && r_state != ST_CONFLICT)  r_conflict <= 1'b0;
    end

    assign conflict = r_conflict;
`else
    // err_clr has no function in this build; the pin is kept for a fixed pinout.
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;

    assign conflict = (r_state == ST_CONFLICT);
`endif

endmodule

// File: tb/tb_gear_switch_conditioner.sv
// Self-checking bench for gear_switch_conditioner with DEBOUNCE_CYCLES=4.
// Expected gear changes are queued when stimulus is driven and popped when
// gear_chg pulses.
module tb_gear_switch_conditioner;
    logic       clk;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic       err_clr;
    logic [3:0] gear_out;
    logic       gear_chg;
    logic       conflict;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    gear_switch_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .RESET_GEAR     (4'b1000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .err_clr (err_clr),
        .gear_out(gear_out),
        .gear_chg(gear_chg),
        .conflict(conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: every gear_chg pulse must match the next queued gear.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ($countones(gear_out) != 1) begin
                errors++;
                $display("FAIL onehot gear_out=%b", gear_out);
            end
            if (gear_chg === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gear_chg gear_out=%b expected no pulse", gear_out);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (gear_out !== e) begin
                        errors++;
                        $display("FAIL scoreboard_gear gear_out=%b expected=%b", gear_out, e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        sw_raw  = 4'b0000;
        err_clr = 1'b0;
        rst_n   = 1'b0;
        tick(2);
        checks++;
        if (gear_out !== 4'b1000 || gear_chg !== 1'b0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got %b/%b/%b expected 1000/0/0", gear_out, gear_chg, conflict);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            checks++;
            if (gear_out !== 4'b1000 || gear_chg !== 1'b0 || conflict !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %b/%b/%b expected 1000/0/0", k, gear_out, gear_chg, conflict);
            end
        end
    endtask

    task automatic test_clean_edge();
        exp_q.push_back(4'b0001);
        sw_raw = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checks++;
            if (gear_out !== 4'b1000 || gear_chg !== 1'b0) begin
                errors++;
                $display("FAIL clean_early edge%0d got %b/%b expected 1000/0", e, gear_out, gear_chg);
            end
        end
        tick(1);
        checks++;
        if (gear_out !== 4'b0001 || gear_chg !== 1'b1 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL clean_edge7 got %b/%b/%b expected 0001/1/0", gear_out, gear_chg, conflict);
        end
        tick(1);
        checks++;
        if (gear_chg !== 1'b0) begin
            errors++;
            $display("FAIL clean_pulse_width gear_chg=%b expected 0", gear_chg);
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 30; k++) begin
            sw_raw = ((k / 3) % 2 == 0) ? 4'b0011 : 4'b0001;
            tick(1);
            checks++;
            if (gear_out !== 4'b0001 || conflict !== 1'b0) begin
                errors++;
                $display("FAIL bounce cyc%0d got %b/%b expected 0001/0", k, gear_out, conflict);
            end
        end
        sw_raw = 4'b0001;
        tick(10);
        checks++;
        if (gear_out !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_settle gear_out=%b expected 0001", gear_out);
        end
    endtask

    task automatic test_conflict();
        sw_raw = 4'b0011;
        tick(6);
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_early conflict=%b expected 0", conflict);
        end
        tick(1);
        checks++;
        if (conflict !== 1'b1 || gear_out !== 4'b0001) begin
            errors++;
            $display("FAIL conflict_set got %b/%b expected 1/0001", conflict, gear_out);
        end
        tick(5);
        exp_q.push_back(4'b0010);
        sw_raw = 4'b0010;
        tick(7);
        checks++;
        if (gear_out !== 4'b0010 || gear_chg !== 1'b1) begin
            errors++;
            $display("FAIL conflict_release got %b/%b expected 0010/1", gear_out, gear_chg);
        end
        tick(3);
`ifdef GEAR_SW_STICKY_ERR_EN
        checks++;
        if (conflict !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold conflict=%b expected 1", conflict);
        end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear conflict=%b expected 0", conflict);
        end
`else
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_clear conflict=%b expected 0", conflict);
        end
`endif
    endtask

    task automatic test_reselect();
        exp_q.push_back(4'b0001);
        sw_raw = 4'b0001;
        tick(7);
        checks++;
        if (gear_out !== 4'b0001 || gear_chg !== 1'b1) begin
            errors++;
            $display("FAIL reselect_move got %b/%b expected 0001/1", gear_out, gear_chg);
        end
        tick(3);
        sw_raw = 4'b0000;
        tick(10);
        checks++;
        if (gear_out !== 4'b0001 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL none_hold got %b/%b expected 0001/0", gear_out, conflict);
        end
        sw_raw = 4'b0001;
        tick(10);
        checks++;
        if (gear_out !== 4'b0001) begin
            errors++;
            $display("FAIL reselect_same gear_out=%b expected 0001", gear_out);
        end
    endtask

    task automatic test_reset_mid();
        sw_raw = 4'b0100;
        tick(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (gear_out !== 4'b1000 || gear_chg !== 1'b0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values got %b/%b/%b expected 1000/0/0", gear_out, gear_chg, conflict);
        end
        tick(1);
        rst_n = 1'b1;
        exp_q.push_back(4'b0100);
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checks++;
            if (gear_out !== 4'b1000) begin
                errors++;
                $display("FAIL midreset_early edge%0d gear_out=%b expected 1000", e, gear_out);
            end
        end
        tick(1);
        checks++;
        if (gear_out !== 4'b0100 || gear_chg !== 1'b1) begin
            errors++;
            $display("FAIL midreset_edge7 got %b/%b expected 0100/1", gear_out, gear_chg);
        end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_conflict();
        test_reselect();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
